// File: rtl/alu_common_pkg.sv
// Shared execute-stage types: opcode encoding, datapath word and instruction address.
package alu_common_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] instruction_memory_address_t;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_MUL  = 5'd2,
        ALU_DIV  = 5'd3,
        ALU_ABS  = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_SEQ  = 5'd6,
        ALU_SNEZ = 5'd7,
        ALU_MIN  = 5'd8,
        ALU_SLL  = 5'd9,
        ALU_ADDI = 5'd10,
        ALU_MULI = 5'd11,
        ALU_DIVI = 5'd12,
        ALU_SEQI = 5'd13,
        ALU_SLLI = 5'd14,
        ALU_BEQO = 5'd15,
        ALU_BEQZ = 5'd16,
        ALU_JAL  = 5'd17
    } alu_instruction_t;

endpackage

// File: rtl/alu_exec_seq_pkg.sv
// Execute-slot constants, FSM state encoding and the single-cycle ALU evaluation function.
// With ITERATIVE_DIV_EN defined, non-zero divides are left to alu_divider.
package alu_exec_seq_pkg;
    import alu_common_pkg::*;

    localparam int    DIV_ITERATIONS  = 32;
    localparam data_t DIV_ZERO_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        DIV  = 2'd2
    } alu_exec_state_t;

    // All compares and divides are unsigned.
    function automatic data_t alu_eval(
        input alu_instruction_t            op,
        input data_t                       op1,
        input data_t                       op2,
        input data_t                       imm,
        input instruction_memory_address_t pc
    );
        data_t res;
        res = '0;
        case (op)
            ALU_ADD:  res = op1 + op2;
            ALU_SUB:  res = op1 - op2;
            ALU_MUL:  res = op1 * op2;
            ALU_ABS:  res = op1[31] ? (~op1 + 32'd1) : op1;
            ALU_SLT:  res = {31'b0, op1 < op2};
            ALU_SEQ:  res = {31'b0, op1 == op2};
            ALU_SNEZ: res = {31'b0, op1 != 32'd0};
            ALU_MIN:  res = (op1 < op2) ? op1 : op2;
            ALU_SLL:  res = (op2 > 32'd31) ? 32'd0 : (op1 << op2[4:0]);
            ALU_ADDI: res = op1 + imm;
            ALU_MULI: res = op1 * imm;
            ALU_SEQI: res = {31'b0, op1 == imm};
            ALU_SLLI: res = op1 << imm[4:0];
            ALU_BEQO: res = {31'b0, op1 == 32'd1};
            ALU_BEQZ: res = {31'b0, op1 == 32'd0};
            ALU_JAL:  res = {{(DATA_W-ADDR_W){1'b0}}, pc} + imm;
`ifdef ITERATIVE_DIV_EN
            ALU_DIV, ALU_DIVI: res = DIV_ZERO_RESULT;
`else
            ALU_DIV:  res = (op2 == 32'd0) ? DIV_ZERO_RESULT : op1 / op2;
            ALU_DIVI: res = (imm == 32'd0) ? DIV_ZERO_RESULT : op1 / imm;
`endif
            default:  res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider, one quotient bit per clock after a start pulse.
// done is asserted during the final step and quotient then shows that step's result.
module alu_divider
    import alu_exec_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);

    logic        running;
    logic [4:0]  count;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] div_r;

    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] quo_next;
    logic [31:0] rem_next;

    // rem stays below the divisor, so the shifted remainder never needs a 34th bit.
    always_comb begin
        rem_shift = {rem, quo[31]};
        diff      = rem_shift - {1'b0, div_r};
        fits      = ~diff[32];
        quo_next  = {quo[30:0], fits};
        rem_next  = fits ? diff[31:0] : rem_shift[31:0];
    end

    assign done     = running && (count == 5'(DIV_ITERATIONS - 1));
    assign quotient = quo_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            div_r   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            quo     <= dividend;
            rem     <= '0;
            div_r   <= divisor;
        end else if (running) begin
            quo   <= quo_next;
            rem   <= rem_next;
            count <= count + 5'd1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute slot between issue and writeback: valid/ready in, one ALU op, valid/ready out.
// Define ITERATIVE_DIV_EN to run non-zero divides through alu_divider (32-cycle latency).
module alu_exec_seq
    import alu_common_pkg::*;
    import alu_exec_seq_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  alu_instruction_t            req_instruction,
    input  instruction_memory_address_t req_pc,
    input  data_t                       req_op1,
    input  data_t                       req_op2,
    input  data_t                       req_imm,
    input  logic [TAG_W-1:0]            req_tag,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output data_t                       rsp_result,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        rsp_div_zero,
    output logic                        busy,
    output alu_exec_state_t             state_dbg
);

    // Handshake: a request moves on an edge where req_valid && req_ready; a response
    // leaves on an edge where rsp_valid && rsp_ready and is held unchanged until then.

    alu_exec_state_t state;
    logic            accept;
    logic            is_div;
    data_t           divisor;
    logic            div_zero;
    data_t           alu_result;
    logic            start_div;

    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign busy      = (state == DIV) || rsp_valid;
    assign state_dbg = state;

    assign is_div     = (req_instruction == ALU_DIV) || (req_instruction == ALU_DIVI);
    assign divisor    = (req_instruction == ALU_DIVI) ? req_imm : req_op2;
    assign div_zero   = is_div && (divisor == 32'd0);
    assign alu_result = alu_eval(req_instruction, req_op1, req_op2, req_imm, req_pc);

`ifdef ITERATIVE_DIV_EN
    logic  div_done;
    data_t div_quotient;

    // A zero divisor is answered immediately and never reaches the divider.
    assign start_div = accept && is_div && !div_zero;

    alu_divider u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_div),
        .dividend (req_op1),
        .divisor  (divisor),
        .done     (div_done),
        .quotient (div_quotient)
    );
`else
    assign start_div = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_tag      <= '0;
            rsp_div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        rsp_tag      <= req_tag;
                        rsp_div_zero <= div_zero;
                        if (start_div) begin
                            state     <= DIV;
                            rsp_valid <= 1'b0;
                        end else begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= alu_result;
                        end
                    end else if ((state == RESP) && rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
`ifdef ITERATIVE_DIV_EN
                DIV: begin
                    if (div_done) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= div_quotient;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq; latency expectations follow ITERATIVE_DIV_EN.
module tb_alu_exec_seq;
    import alu_common_pkg::*;
    import alu_exec_seq_pkg::*;

    localparam int TAG_W = 5;

    logic                        clk;
    logic                        rst_n;
    logic                        req_valid;
    logic                        req_ready;
    alu_instruction_t            req_instruction;
    instruction_memory_address_t req_pc;
    data_t                       req_op1;
    data_t                       req_op2;
    data_t                       req_imm;
    logic [TAG_W-1:0]            req_tag;
    logic                        rsp_valid;
    logic                        rsp_ready;
    data_t                       rsp_result;
    logic [TAG_W-1:0]            rsp_tag;
    logic                        rsp_div_zero;
    logic                        busy;
    alu_exec_state_t             state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    alu_exec_seq #(.TAG_W(TAG_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_instruction (req_instruction),
        .req_pc          (req_pc),
        .req_op1         (req_op1),
        .req_op2         (req_op2),
        .req_imm         (req_imm),
        .req_tag         (req_tag),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_tag         (rsp_tag),
        .rsp_div_zero    (rsp_div_zero),
        .busy            (busy),
        .state_dbg       (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input alu_instruction_t op, input data_t a, input data_t b,
                             input data_t imm, input instruction_memory_address_t pc,
                             input logic [TAG_W-1:0] tag);
        req_valid       = 1'b1;
        req_instruction = op;
        req_op1         = a;
        req_op2         = b;
        req_imm         = imm;
        req_pc          = pc;
        req_tag         = tag;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_op1   = $urandom;
        req_op2   = $urandom;
        req_imm   = $urandom;
    endtask

    task automatic run_vec(input string name, input alu_instruction_t op, input data_t a,
                           input data_t b, input data_t imm, input data_t exp);
        drive_req(op, a, b, imm, 16'd0, 5'd20);
        tick();
        idle_req();
        check(name, rsp_result, exp);
        tick();
    endtask

    logic seen_valid;

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive_req(ALU_ADD, 32'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        idle_req();
        repeat (2) tick();

        // reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_div_zero", 32'(rsp_div_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        // ADD 7 + 5, tag 3
        drive_req(ALU_ADD, 32'd7, 32'd5, 32'd0, 16'd0, 5'd3);
        check("add_req_ready", 32'(req_ready), 32'd1);
        tick();
        idle_req();
        check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_result", rsp_result, 32'd12);
        check("add_tag", 32'(rsp_tag), 32'd3);
        check("add_req_ready_after", 32'(req_ready), 32'd1);
        tick();
        check("add_drop", 32'(rsp_valid), 32'd0);

        // back-to-back SUB, SLL, JAL
        drive_req(ALU_SUB, 32'd10, 32'd3, 32'd0, 16'd0, 5'd1);
        exp_q.push_back(32'd7);
        tick();
        check("b2b_sub_valid", 32'(rsp_valid), 32'd1);
        check("b2b_sub", rsp_result, exp_q.pop_front());
        drive_req(ALU_SLL, 32'd1, 32'd40, 32'd0, 16'd0, 5'd2);
        exp_q.push_back(32'd0);
        tick();
        check("b2b_sll_tag", 32'(rsp_tag), 32'd2);
        check("b2b_sll", rsp_result, exp_q.pop_front());
        drive_req(ALU_JAL, 32'd0, 32'd0, 32'd8, 16'd100, 5'd4);
        exp_q.push_back(32'd108);
        tick();
        idle_req();
        check("b2b_jal", rsp_result, exp_q.pop_front());
        check("b2b_jal_tag", 32'(rsp_tag), 32'd4);
        tick();
        check("b2b_drop", 32'(rsp_valid), 32'd0);

        // backpressure: ABS held, queued MIN
        rsp_ready = 1'b0;
        drive_req(ALU_ABS, 32'hFFFF_FFFB, 32'd0, 32'd0, 16'd0, 5'd7);
        tick();
        drive_req(ALU_MIN, 32'd4, 32'd9, 32'd0, 16'd0, 5'd8);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_result", rsp_result, 32'd5);
            check("bp_hold_tag", 32'(rsp_tag), 32'd7);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        tick();
        idle_req();
        check("bp_min_valid", 32'(rsp_valid), 32'd1);
        check("bp_min", rsp_result, 32'd4);
        check("bp_min_tag", 32'(rsp_tag), 32'd8);
        tick();
        check("bp_drop", 32'(rsp_valid), 32'd0);

        // assorted opcodes
        run_vec("slt", ALU_SLT, 32'd3, 32'd9, 32'd0, 32'd1);
        run_vec("slt_unsigned", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        run_vec("seqi", ALU_SEQI, 32'd5, 32'd0, 32'd5, 32'd1);
        run_vec("slli_mask", ALU_SLLI, 32'd1, 32'd0, 32'd33, 32'd2);
        run_vec("sll_31", ALU_SLL, 32'd1, 32'd31, 32'd0, 32'h8000_0000);
        run_vec("beqo", ALU_BEQO, 32'd1, 32'd0, 32'd0, 32'd1);
        run_vec("beqz", ALU_BEQZ, 32'd4, 32'd0, 32'd0, 32'd0);
        run_vec("snez", ALU_SNEZ, 32'd0, 32'd0, 32'd0, 32'd0);
        run_vec("muli_wrap", ALU_MULI, 32'h0001_0000, 32'd0, 32'h0001_0003, 32'h0003_0000);
        run_vec("addi_wrap", ALU_ADDI, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd1);
        run_vec("abs_pos", ALU_ABS, 32'd9, 32'd0, 32'd0, 32'd9);
        run_vec("unknown", alu_instruction_t'(5'h1F), 32'd6, 32'd6, 32'd6, 32'd0);

        // DIV 100 / 7
        drive_req(ALU_DIV, 32'd100, 32'd7, 32'd0, 16'd0, 5'd9);
        tick();
        idle_req();
`ifdef ITERATIVE_DIV_EN
        for (int k = 0; k < DIV_ITERATIONS; k++) begin
            check("div_req_ready_low", 32'(req_ready), 32'd0);
            check("div_no_valid", 32'(rsp_valid), 32'd0);
            check("div_busy", 32'(busy), 32'd1);
            tick();
        end
`endif
        check("div_valid", 32'(rsp_valid), 32'd1);
        check("div_result", rsp_result, 32'd14);
        check("div_tag", 32'(rsp_tag), 32'd9);
        check("div_zero_flag", 32'(rsp_div_zero), 32'd0);
        tick();

        // DIVI by zero
        drive_req(ALU_DIVI, 32'd55, 32'd3, 32'd0, 16'd0, 5'd10);
        tick();
        idle_req();
        check("dz_valid", 32'(rsp_valid), 32'd1);
        check("dz_result", rsp_result, 32'hFFFF_FFFF);
        check("dz_flag", 32'(rsp_div_zero), 32'd1);
        tick();
        check("dz_drop", 32'(rsp_valid), 32'd0);

        // reset mid-operation
`ifdef ITERATIVE_DIV_EN
        drive_req(ALU_DIV, 32'd1000, 32'd3, 32'd0, 16'd0, 5'd11);
        tick();
        idle_req();
        repeat (10) tick();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_state", 32'(state_dbg), 32'(DIV));
`else
        rsp_ready = 1'b0;
        drive_req(ALU_ADD, 32'd2, 32'd2, 32'd0, 16'd0, 5'd11);
        tick();
        idle_req();
        check("mid_valid_held", 32'(rsp_valid), 32'd1);
        check("mid_state", 32'(state_dbg), 32'(RESP));
`endif
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rsp_valid) seen_valid = 1'b1;
        end
        check("mid_no_response", 32'(seen_valid), 32'd0);
        check("mid_idle_ready", 32'(req_ready), 32'd1);
        check("mid_idle_state", 32'(state_dbg), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Sequential execute wrapper that sits between the issue stage and register writeback. It accepts one ALU operation per cycle over a valid/ready request channel and evaluates it with the team's ALU opcode semantics. It returns the result, with its destination tag, over a valid/ready response channel. Divides may be executed by an iterative divider, so the block owns all backpressure and busy signalling for the execute slot.

## Interface
Parameters:
- TAG_W, 5: width of the destination register tag carried alongside the operation.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on this edge when high together with req_valid.
- req_instruction  in  alu_instruction_t  opcode.
- req_pc  in  instruction_memory_address_t  PC of the operation; used only by JAL.
- req_op1, req_op2, req_imm  in  data_t  operands.
- req_tag  in  TAG_W  destination tag.
- rsp_valid  out  1  result held.
- rsp_ready  in  1  consumer takes the result on this edge.
- rsp_result  out  data_t  result.
- rsp_tag  out  TAG_W  tag of the result.
- rsp_div_zero  out  1  result came from DIV/DIVI with a zero divisor.
- busy  out  1  high in DIV state or while rsp_valid is high.

## Operation
- Opcode semantics. All compares and divides are unsigned on data_t.
  - ADD, SUB, MUL: low 32 bits of the result.
  - ABS: negate when op1[31] is set.
  - SLT, SEQ, SNEZ, MIN: as per the opcode names.
  - SLL: op1 << op2 using the full op2, so any shift of 32 or more gives 0.
  - ADDI, MULI, DIVI, SEQI: use req_imm as the second operand.
  - SLLI: shifts by imm[4:0].
  - BEQO: 1 iff op1 == 1. BEQZ: 1 iff op1 == 0.
  - JAL: pc + imm, zero-extended PC.
  - Unknown opcode: 0.
- DIV/DIVI with a zero divisor: result 32'hFFFF_FFFF, rsp_div_zero = 1. The divider is never started.
- States:
  - IDLE: no result held.
  - RESP: result held, rsp_valid = 1.
  - DIV: iterative divide in progress (only with ITERATIVE_DIV_EN).
- Transitions:
  - IDLE, accept a non-divide (or divide-by-zero) op → RESP.
  - IDLE, accept a divide → DIV.
  - DIV, on the last iteration → RESP.
  - RESP, rsp_ready with no new request → IDLE.
  - RESP, rsp_ready with a new request accepted on the same edge → RESP or DIV, following the IDLE rules.
- req_ready = (state == IDLE) || (state == RESP && rsp_ready). It is low throughout DIV.
- rsp_result, rsp_tag and rsp_div_zero are stable while rsp_valid is high and rsp_ready is low.
- Operands are captured at acceptance. Request inputs are don't-care afterwards.

## Timing
- Reset values: rsp_valid 0, rsp_result 0, rsp_tag 0, rsp_div_zero 0, busy 0, req_ready 1 (IDLE). Divider state is cleared.
- Reset mid-operation, whether in DIV or RESP: the operation is discarded and no response is ever produced for it.
- Non-divide op accepted at edge N: rsp_valid is high after edge N (1-cycle latency). Sustained throughput is 1 op per cycle when rsp_ready is held high.
- Divide-by-zero: same 1-cycle latency as a non-divide op.
- Iterative divide accepted at edge N: one quotient bit per edge, N+1 through N+32. rsp_valid is high after edge N+32 (32-cycle latency).
- Response drop: rsp_valid falls after the pop edge unless a non-divide op is accepted on that same edge.

## Configuration
- ITERATIVE_DIV_EN defined:
  - DIV/DIVI run through the iterative divider with the latency given under Timing.
  - The DIV state exists and busy covers it.
- ITERATIVE_DIV_EN not defined:
  - DIV/DIVI compute combinationally like every other opcode, with 1-cycle latency.
  - The DIV state is absent.
  - Divide-by-zero still returns 32'hFFFF_FFFF with the flag set.

## Structure
- alu_instruction_t, data_t and instruction_memory_address_t remain in common.svh.
- Add to the shared package:
  - constant DIV_ITERATIONS = 32;
  - state enum alu_exec_state_t {IDLE, RESP, DIV};
  - DIV_ZERO_RESULT = 32'hFFFF_FFFF.
- One sub-module, alu_divider: restoring unsigned divider with start/done handshake and 32-bit dividend/divisor/quotient. It is instantiated only under ITERATIVE_DIV_EN.

## Test plan
- Reset then ADD: op1 = 7, op2 = 5, tag 3, rsp_ready = 1 → rsp_result 12 and rsp_tag 3, one cycle after accept; req_ready stays 1.
- Back-to-back: SUB 10−3, then SLL 1 << 40, then JAL pc = 100 imm = 8 on consecutive cycles with rsp_ready = 1 → 7, 0, 108 on consecutive cycles.
- Backpressure: ABS op1 = 32'hFFFF_FFFB, rsp_ready = 0 for 3 cycles → rsp_result holds 5 and req_ready = 0; on release, a queued MIN 4, 9 returns 4 on the next cycle.
- Iterative divide: DIV 100 / 7 → req_ready low for 32 cycles, then rsp_result 14, rsp_div_zero 0.
- Divide by zero: DIVI op1 = 55, imm = 0 → 32'hFFFF_FFFF, rsp_div_zero 1, one-cycle latency.
- Reset in DIV: assert rst_n low at iteration 10 of DIV 1000 / 3 → rsp_valid never rises, and the block returns to IDLE with req_ready 1.
